// File: rtl/exp5_gravador_jogadas.sv
// Play-sequence recorder: stores one-hot switch entries into a 16x4 sync RAM, one word per button press.
// Latency: press edge to RAM write 2 clocks; accepted entries at most every 4 clocks; read data 1 clock after address.
// Backpressure: none; presses arriving outside ESPERA are ignored, and non-one-hot presses pulse jogada_invalida.
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   iniciar                   start/restart a recording (level)
//   jogada, chaves            entry button (edge-detected) and switch value
//   endereco_leitura          read address, independent of the writer
//   dado_leitura              RAM[endereco_leitura], registered, read-first
//   pronto                    high while the recording is complete (FIM)
//   jogada_invalida           one-cycle pulse on a press whose chaves is not one-hot
//   db_contagem, db_chaves,   debug: write address, entry register, FSM code
//   db_estado
module exp5_gravador_jogadas #(
  parameter int WIDTH     = 4,
  parameter int ADDR_W    = 4,
  parameter int N_JOGADAS = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              jogada,
  input  logic [WIDTH-1:0]  chaves,
  input  logic [ADDR_W-1:0] endereco_leitura,
  output logic [WIDTH-1:0]  dado_leitura,
  output logic              pronto,
  output logic              jogada_invalida,
  output logic [ADDR_W-1:0] db_contagem,
  output logic [WIDTH-1:0]  db_chaves,
  output logic [3:0]        db_estado
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(N_JOGADAS - 1);

  typedef enum logic [3:0] {
    INICIAL  = 4'h0,
    PREPARA  = 4'h1,
    ESPERA   = 4'h2,
    REGISTRA = 4'h3,
    GRAVA    = 4'h4,
    PROXIMO  = 4'h5,
    FIM      = 4'hF
  } estado_t;

  estado_t           estado, prox;
  logic [ADDR_W-1:0] contagem;
  logic [WIDTH-1:0]  registro;
  logic              jogada_q;
  logic              press;
  logic              one_hot;
  logic [WIDTH-1:0]  mem [0:DEPTH-1];

  // A held button produces a single press; release is required before the next one.
  assign press   = jogada & ~jogada_q;
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign one_hot = (chaves != '0) && ((chaves & (chaves - WIDTH'(1))) == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= INICIAL;
      contagem <= '0;
      registro <= '0;
      jogada_q <= 1'b0;
    end else begin
      estado   <= prox;
      jogada_q <= jogada;
      case (estado)
        PREPARA: begin
          contagem <= '0;
          registro <= '0;
        end
        REGISTRA: registro <= chaves;
        PROXIMO:  contagem <= contagem + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:  if (iniciar) prox = PREPARA;
      PREPARA:  prox = ESPERA;
      ESPERA:   if (press && one_hot) prox = REGISTRA;
      REGISTRA: prox = GRAVA;
      GRAVA:    prox = (contagem == ULTIMO) ? FIM : PROXIMO;
      PROXIMO:  prox = ESPERA;
      FIM:      if (iniciar) prox = PREPARA;
      default:  prox = INICIAL;
    endcase
  end

  // RAM contents survive reset; the write is still suppressed during a reset cycle.
  always_ff @(posedge clock) begin
    if (!reset && estado == GRAVA) begin
      mem[contagem] <= registro;
    end
  end

  // Non-blocking read alongside the write gives read-first behaviour on a collision.
  always_ff @(posedge clock) begin
    if (reset) begin
      dado_leitura <= '0;
    end else begin
      dado_leitura <= mem[endereco_leitura];
    end
  end

  assign pronto          = (estado == FIM);
  assign jogada_invalida = (estado == ESPERA) && press && !one_hot;
  assign db_contagem     = contagem;
  assign db_chaves       = registro;
  assign db_estado       = estado;

endmodule

// File: tb/tb_exp5_gravador_jogadas.sv
// Bench for exp5_gravador_jogadas: directed recordings with a read-data scoreboard.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_exp5_gravador_jogadas;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       jogada;
  logic [3:0] chaves;
  logic [3:0] endereco_leitura;
  logic [3:0] dado_leitura;
  logic       pronto;
  logic       jogada_invalida;
  logic [3:0] db_contagem;
  logic [3:0] db_chaves;
  logic [3:0] db_estado;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] model_mem [0:15];
  logic [3:0] exp_q [$];

  exp5_gravador_jogadas #(.WIDTH(4), .ADDR_W(4), .N_JOGADAS(16)) dut (
    .clock            (clock),
    .reset            (reset),
    .iniciar          (iniciar),
    .jogada           (jogada),
    .chaves           (chaves),
    .endereco_leitura (endereco_leitura),
    .dado_leitura     (dado_leitura),
    .pronto           (pronto),
    .jogada_invalida  (jogada_invalida),
    .db_contagem      (db_contagem),
    .db_chaves        (db_chaves),
    .db_estado        (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One press pulse, then wait (bounded) for the FSM to settle in ESPERA or FIM.
  task automatic press(input logic [3:0] v);
    int k;
    chaves = v;
    jogada = 1'b1;
    step();
    jogada = 1'b0;
    k = 0;
    while (db_estado != 4'h2 && db_estado != 4'hF && k < 10) begin
      step();
      k++;
    end
    if (k >= 10) check("press_settle", 32'(db_estado), 32'h2);
  endtask

  task automatic iniciar_gravacao();
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    step();
    check("start_espera", 32'(db_estado), 32'h2);
  endtask

  // Pipelined readback: expected word queued with the address, popped one clock later.
  task automatic readback(input int first, input int last);
    logic [3:0] e;
    endereco_leitura = 4'(first);
    exp_q.push_back(model_mem[first]);
    for (int a = first; a <= last; a++) begin
      step();
      e = exp_q.pop_front();
      check($sformatf("read_%0d", a - 1 + 1), 32'(dado_leitura), 32'(e));
      if (a < last) begin
        endereco_leitura = 4'(a + 1);
        exp_q.push_back(model_mem[a + 1]);
      end
    end
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    iniciar = 1'b0;
    jogada = 1'b0;
    chaves = 4'b0000;
    endereco_leitura = 4'h0;
    step();
    step();
    check("rst_estado", 32'(db_estado), 32'h0);
    check("rst_pronto", 32'(pronto), 32'h0);
    check("rst_contagem", 32'(db_contagem), 32'h0);
    check("rst_chaves", 32'(db_chaves), 32'h0);
    check("rst_dado", 32'(dado_leitura), 32'h0);
    check("rst_invalida", 32'(jogada_invalida), 32'h0);
    reset = 1'b0;
    step();
    check("idle_inicial", 32'(db_estado), 32'h0);

    // Full recording of 16 one-hot entries.
    iniciar_gravacao();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'b0001 << (i % 4);
      model_mem[i] = v;
      press(v);
      if (i < 15) check($sformatf("cnt_after_%0d", i), 32'(db_contagem), 32'(i + 1));
    end
    check("full_pronto", 32'(pronto), 32'h1);
    check("full_estado", 32'(db_estado), 32'hF);
    check("full_contagem", 32'(db_contagem), 32'hF);
    readback(0, 15);

    // Presses in FIM are ignored.
    press(4'b0001);
    check("fim_ignores_estado", 32'(db_estado), 32'hF);
    check("fim_ignores_cnt", 32'(db_contagem), 32'hF);

    // Restart from FIM: overwrite address 0 only.
    iniciar_gravacao();
    check("restart_pronto", 32'(pronto), 32'h0);
    check("restart_cnt", 32'(db_contagem), 32'h0);
    model_mem[0] = 4'b1000;
    press(4'b1000);
    check("restart_cnt1", 32'(db_contagem), 32'h1);
    readback(0, 15);

    // Invalid presses: 0011 and 0000.
    chaves = 4'b0011;
    jogada = 1'b1;
    #1;
    check("inval_0011", 32'(jogada_invalida), 32'h1);
    step();
    check("inval_0011_pulse", 32'(jogada_invalida), 32'h0);
    jogada = 1'b0;
    step();
    chaves = 4'b0000;
    jogada = 1'b1;
    #1;
    check("inval_0000", 32'(jogada_invalida), 32'h1);
    step();
    jogada = 1'b0;
    step();
    check("inval_estado", 32'(db_estado), 32'h2);
    check("inval_cnt", 32'(db_contagem), 32'h1);
    readback(1, 1);
    model_mem[1] = 4'b0100;
    press(4'b0100);
    check("after_inval_cnt", 32'(db_contagem), 32'h2);
    readback(1, 1);

    // Held button counts once.
    cnt = int'(db_contagem);
    chaves = 4'b0001;
    jogada = 1'b1;
    repeat (20) step();
    jogada = 1'b0;
    step();
    model_mem[cnt] = 4'b0001;
    check("hold_cnt", 32'(db_contagem), 32'(cnt + 1));
    check("hold_estado", 32'(db_estado), 32'h2);
    readback(cnt, cnt);

    // Read/write collision at address 3: old data, then new data.
    check("coll_cnt", 32'(db_contagem), 32'h3);
    chaves = 4'b0010;
    jogada = 1'b1;
    step();
    jogada = 1'b0;
    check("coll_registra", 32'(db_estado), 32'h3);
    step();
    check("coll_grava", 32'(db_estado), 32'h4);
    check("coll_db_chaves", 32'(db_chaves), 32'h2);
    endereco_leitura = 4'h3;
    exp_q.push_back(model_mem[3]);
    step();
    check("coll_old", 32'(dado_leitura), 32'(exp_q.pop_front()));
    model_mem[3] = 4'b0010;
    exp_q.push_back(model_mem[3]);
    step();
    check("coll_new", 32'(dado_leitura), 32'(exp_q.pop_front()));
    check("coll_back_espera", 32'(db_estado), 32'h2);

    // Fifth entry, then reset mid-recording.
    model_mem[4] = 4'b1000;
    press(4'b1000);
    check("five_cnt", 32'(db_contagem), 32'h5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_estado", 32'(db_estado), 32'h0);
    check("midrst_pronto", 32'(pronto), 32'h0);
    check("midrst_cnt", 32'(db_contagem), 32'h0);
    readback(0, 15);

    check("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
